hex_tx_formatter: RTL and testbench
===================================

# hex_tx_formatter

Transmit-side formatter for the debug control panel: it turns a print request from a command child into a stream of ASCII bytes on the UART transmit byte interface. It is the counterpart of the hex-scanning receiver: where the receiver collects ASCII hex digits into a 32-bit word, this block expands a 32-bit word, or a single character, into ASCII hex digits. It sits between the panel's command multiplexer (`req_tx`/`type_tx`/`dout_tx`/`ack_tx`) and the UART transmitter (`d_tx`/`vld_tx`/`rdy_tx`).

## Interface
Parameters: none.

Ports:
- `clk` in 1 — system clock; one clock domain.
- `rst` in 1 — reset, synchronous and active-high.
- `req_tx` in 1 — print request, level-sensitive; held by the requester until `ack_tx`.
- `type_tx` in 1 — request type: 0 = single character `dout_tx[7:0]`; 1 = 32-bit word as hex.
- `dout_tx` in 32 — data to print; sampled only at request acceptance.
- `ack_tx` out 1 — one-cycle pulse after the last byte of a request is accepted.
- `busy_tx` out 1 — high from request acceptance until the block returns to IDLE.
- `d_tx` out 8 — ASCII byte to the UART transmitter.
- `vld_tx` out 1 — `d_tx` valid.
- `rdy_tx` in 1 — the UART transmitter can take a byte.

## Operation
- States: IDLE, SEND, DONE, REL.
- IDLE:
  - When `req_tx`=1, latch `dout_tx` into the shift register and `type_tx` into the type flag.
  - Load the first character into `d_tx`, set `vld_tx`=1 and `busy_tx`=1, then go to SEND.
- SEND:
  - A byte transfers on any edge where `vld_tx`&`rdy_tx`=1.
  - On a transfer that is not the last byte, load the next byte in the same edge, so `vld_tx` stays high.
  - On the last transfer, drop `vld_tx` and go to DONE.
- Byte sequence:
  - Type 0: one byte, `dout_tx[7:0]` verbatim.
  - Type 1: 8 digits, most significant nibble first (bits 31:28 first).
  - Nibble to ASCII: values 0–9 map to 0x30–0x39; values A–F map to 0x41–0x46 (uppercase only).
- Byte counter: 4 bits; the last index is 0 for type 0, 7 for type 1, or 9 for type 1 with CRLF (see Configuration).
- DONE: `ack_tx`=1 for exactly one cycle, then go to REL.
- REL:
  - Wait for `req_tx`=0, then go to IDLE and drop `busy_tx`.
  - A request held high across `ack_tx` is never printed twice.
- The latched data and type do not change during SEND, whatever `dout_tx` or `type_tx` do.
- `d_tx` is stable for as long as `vld_tx`=1 and the byte has not transferred.
- `req_tx` going low during SEND or DONE has no effect: the request runs to completion.

## Timing
- Reset values, at the first `clk` edge with `rst`=1:
  - `d_tx`=0x00, `vld_tx`=0, `ack_tx`=0, `busy_tx`=0.
  - State IDLE, counter 0.
- Reset mid-request: the rest of the request is dropped with no `ack_tx`. A byte that is valid but not yet transferred is withdrawn.
- Latency: `req_tx` sampled high at edge N → `vld_tx`=1 with the first byte in cycle N+1.
- With `rdy_tx` held at 1, one byte transfers per cycle.
- Type 1 without CRLF:
  - Transfers occur at edges N+1 … N+8.
  - `ack_tx`=1 in the cycle after edge N+8.
  - Earliest return to IDLE is after edge N+10, if `req_tx` is low by then.
- `rdy_tx`=0 stalls the block indefinitely with no loss of data; `vld_tx` is not withdrawn.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `HEX_TX_CRLF_EN` defined:
  - Type-1 requests append 0x0D then 0x0A after the 8 digits, for 10 bytes total.
  - Type-0 requests are unchanged.
- `HEX_TX_CRLF_EN` undefined: type-1 requests are exactly 8 bytes, and the counter never exceeds 7.

## Test plan
- Type 1, `dout_tx`=0x1234ABCD, `rdy_tx`=1 → bytes 0x31 0x32 0x33 0x34 0x41 0x42 0x43 0x44 on consecutive cycles, then a single `ack_tx` pulse. With `HEX_TX_CRLF_EN`, 0x0D 0x0A follow before `ack_tx`.
- Type 0, `dout_tx[7:0]`=0x3E → exactly one byte 0x3E, `ack_tx` one cycle later, `busy_tx` held until `req_tx` drops.
- Type 1, `dout_tx`=0xF0000009, `rdy_tx` toggling 1/0 every cycle → sequence 0x46, then six 0x30, then 0x39. No byte is duplicated or skipped, and `d_tx` is stable while stalled.
- `req_tx` held high for 30 cycles after `ack_tx` → no second print, `busy_tx`=1. After `req_tx` falls, a new request is accepted.
- `rst` asserted after the third digit of a type-1 request → next cycle `vld_tx`=0 and `ack_tx` never pulses. A fresh request afterwards prints all 8 digits correctly.
- `dout_tx` changed at every cycle during SEND → the output is the digits of the value latched at acceptance.

Source files
------------

// File: rtl/hex_tx_formatter.sv
// Expands a print request (single character or 32-bit word) into ASCII bytes for the UART transmitter.
// Optional feature: define HEX_TX_CRLF_EN to append CR LF after each 8-digit word.
module hex_tx_formatter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_tx,
  input  logic        type_tx,
  input  logic [31:0] dout_tx,
  output logic        ack_tx,
  output logic        busy_tx,
  output logic [7:0]  d_tx,
  output logic        vld_tx,
  input  logic        rdy_tx
);

  typedef enum logic [1:0] {IDLE, SEND, DONE, REL} state_t;

`ifdef HEX_TX_CRLF_EN
  localparam logic [3:0] LAST_HEX = 4'd9;
`else
  localparam logic [3:0] LAST_HEX = 4'd7;
`endif

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  state_t      state_q, state_d;
  // First digit goes straight to d_tx, so only the remaining 7 nibbles are kept.
  logic [27:0] shreg_q, shreg_d;
  logic        type_q, type_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  d_q, d_d;
  logic        vld_q, vld_d;
  logic        ack_q, ack_d;
  logic        busy_q, busy_d;

  logic [3:0]  last_idx;
  logic [3:0]  nxt_cnt;
  logic [7:0]  nxt_byte;

  always_comb begin
    last_idx = type_q ? LAST_HEX : 4'd0;
    nxt_cnt  = cnt_q + 4'd1;
    nxt_byte = hex_ascii(shreg_q[27:24]);
`ifdef HEX_TX_CRLF_EN
    if (nxt_cnt == 4'd8)      nxt_byte = 8'h0D;
    else if (nxt_cnt == 4'd9) nxt_byte = 8'h0A;
`endif
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    type_d  = type_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    vld_d   = vld_q;
    ack_d   = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (req_tx) begin
          shreg_d = dout_tx[27:0];
          type_d  = type_tx;
          cnt_d   = 4'd0;
          d_d     = type_tx ? hex_ascii(dout_tx[31:28]) : dout_tx[7:0];
          vld_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (vld_q && rdy_tx) begin
          if (cnt_q == last_idx) begin
            vld_d   = 1'b0;
            ack_d   = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d   = nxt_cnt;
            shreg_d = {shreg_q[23:0], 4'h0};
            d_d     = nxt_byte;
          end
        end
      end
      DONE: state_d = REL;
      REL: begin
        // Hold here until the requester lets go so a held request is not reprinted.
        if (!req_tx) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      type_q  <= 1'b0;
      cnt_q   <= 4'd0;
      d_q     <= 8'h00;
      vld_q   <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      type_q  <= type_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      vld_q   <= vld_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign d_tx    = d_q;
  assign vld_tx  = vld_q;
  assign ack_tx  = ack_q;
  assign busy_tx = busy_q;

endmodule

// File: tb/tb_hex_tx_formatter.sv
// Scoreboard bench for hex_tx_formatter: requests push expected ASCII bytes, a monitor pops on each transfer.
module tb_hex_tx_formatter;
  logic        clk = 1'b0;
  logic        rst, req_tx, type_tx, ack_tx, busy_tx, vld_tx, rdy_tx;
  logic [31:0] dout_tx;
  logic [7:0]  d_tx;

  hex_tx_formatter dut (
    .clk(clk), .rst(rst), .req_tx(req_tx), .type_tx(type_tx), .dout_tx(dout_tx),
    .ack_tx(ack_tx), .busy_tx(busy_tx), .d_tx(d_tx), .vld_tx(vld_tx), .rdy_tx(rdy_tx)
  );

  always #5 clk = ~clk;

  int         checks = 0, errors = 0;
  int         ack_cnt = 0, xfer_cnt = 0;
  int         rdy_mode = 0;
  bit         scramble = 0;
  logic [7:0] exp_q[$];
  bit         stall_q = 0, ack_prev = 0;
  logic [7:0] stall_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: ASCII text the request should produce.
  task automatic push_exp(input logic t, input logic [31:0] d);
    int nib;
    if (!t) exp_q.push_back(d[7:0]);
    else begin
      for (int i = 0; i < 8; i++) begin
        nib = int'((d >> (28 - 4 * i)) & 32'hF);
        exp_q.push_back(nib < 10 ? 8'(48 + nib) : 8'(55 + nib));
      end
`ifdef HEX_TX_CRLF_EN
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
`endif
    end
  endtask

  // Input driver: ready pattern and optional scrambling of data/type while a request is in flight.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: rdy_tx = 1'b1;
      1: rdy_tx = ~rdy_tx;
      2: rdy_tx = 1'($urandom);
      default: rdy_tx = 1'b0;
    endcase
    if (scramble) begin
      dout_tx = $urandom;
      type_tx = 1'($urandom);
    end
  end

  // Monitor: a transfer happens on the coming edge when vld&rdy are high mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (stall_q && vld_tx) chk("stall_stable", {24'h0, d_tx}, {24'h0, stall_d});
      if (vld_tx && rdy_tx) begin
        if (exp_q.size() == 0) chk("unexpected_byte", {24'h0, d_tx}, 32'hFFFF_FFFF);
        else chk("byte", {24'h0, d_tx}, {24'h0, exp_q.pop_front()});
        xfer_cnt++;
      end
      stall_q = vld_tx && !rdy_tx;
      stall_d = d_tx;
      if (ack_tx) begin
        chk("ack_single_cycle", {31'h0, ack_prev}, 32'h0);
        chk("ack_after_last", exp_q.size(), 0);
        ack_cnt++;
      end
      ack_prev = ack_tx;
    end else begin
      stall_q  = 1'b0;
      ack_prev = 1'b0;
    end
  end

  task automatic run_req(input logic t, input logic [31:0] d, input int mode, input bit scr,
                         input int hold);
    int a0;
    @(posedge clk); #1;
    rdy_mode = mode; type_tx = t; dout_tx = d; req_tx = 1'b1;
    push_exp(t, d);
    a0 = ack_cnt;
    @(posedge clk); #1;
    chk("first_byte_latency", {30'h0, vld_tx, busy_tx}, 32'h3);
    scramble = scr;
    for (int i = 0; i < 400 && ack_cnt == a0; i++) @(posedge clk);
    #1;
    scramble = 1'b0;
    chk("ack_seen", ack_cnt, a0 + 1);
    repeat (hold) @(posedge clk);
    #1;
    chk("busy_while_req_held", {31'h0, busy_tx}, 32'h1);
    chk("no_reprint", ack_cnt, a0 + 1);
    chk("queue_drained", exp_q.size(), 0);
    req_tx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("busy_released", {31'h0, busy_tx}, 32'h0);
  endtask

  initial begin
    int a0, x0;
    rst = 1'b1; req_tx = 1'b0; type_tx = 1'b0; dout_tx = '0; rdy_tx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {d_tx, 20'h0, vld_tx, ack_tx, busy_tx, 1'b0}, 32'h0);
    rst = 1'b0;

    run_req(1'b1, 32'h1234ABCD, 0, 1'b0, 0);
    run_req(1'b0, 32'h0000003E, 0, 1'b0, 2);
    run_req(1'b1, 32'hF0000009, 1, 1'b0, 0);
    run_req(1'b1, 32'h00000000, 0, 1'b0, 30);
    run_req(1'b1, 32'hC0FFEE42, 2, 1'b1, 1);

    // Reset in the middle of a word after the third digit.
    @(posedge clk); #1;
    rdy_mode = 0; type_tx = 1'b1; dout_tx = 32'hDEADBEEF; req_tx = 1'b1;
    push_exp(1'b1, 32'hDEADBEEF);
    a0 = ack_cnt; x0 = xfer_cnt;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (xfer_cnt - x0 >= 3) break;
    end
    chk("three_digits_sent", xfer_cnt - x0, 3);
    rdy_mode = 3; rdy_tx = 1'b0; rst = 1'b1; req_tx = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    chk("reset_withdraws", {d_tx, 21'h0, vld_tx, busy_tx, 1'b0}, 32'h0);
    repeat (12) @(posedge clk);
    #1;
    chk("no_ack_after_reset", ack_cnt, a0);
    run_req(1'b1, 32'h89ABCDEF, 0, 1'b0, 0);

    for (int n = 0; n < 20; n++)
      run_req(1'($urandom), $urandom, $urandom_range(0, 2), 1'($urandom), $urandom_range(0, 3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
